// File: rtl/trace_pkg.sv
// Shared types for the retire trace capture stage.
// Optional feature macro: RETIRE_TRACE_PC_EN (adds a PC field to every record).
package trace_pkg;

    // Bit positions inside the 4-bit flag field {hlt, mem_write, mem_read, reg_write}
    localparam int FLG_REG = 0;
    localparam int FLG_LD  = 1;
    localparam int FLG_ST  = 2;
    localparam int FLG_HLT = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } trace_state_t;

    typedef struct packed {
`ifdef RETIRE_TRACE_PC_EN
        logic [15:0] pc;
`endif
        logic [3:0]  flags;
        logic [3:0]  reg_sel;
        logic [15:0] reg_data;
        logic [15:0] mem_addr;
        logic [15:0] mem_data;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records.
// Pointers carry one wrap bit above the index so full and empty are distinct.
// A push into a full FIFO is accepted only when a pop frees the head in the
// same cycle; push_ok tells the caller whether the record was stored.
// Handshake: pop is only honoured when the FIFO is not empty; the head record
// is presented on rd_rec and held stable until popped (zero when empty).
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  trace_rec_t               wr_rec,
    output trace_rec_t               rd_rec,
    output logic                     push_ok,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    trace_rec_t  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        pop_ok;

    // Status, acceptance and pointer advance
    always_comb begin
        occupancy = wr_ptr_q - rd_ptr_q;
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (occupancy == DEPTH_CNT);
        pop_ok    = pop && !empty;
        push_ok   = push && (!full || pop_ok);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        rd_rec    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset because the head is masked when empty
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_rec;
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Commit-trace capture stage behind the CPU MEM/WB boundary.
// Captures write-back, memory and halt activity into a FIFO, keeps cycle and
// retired-instruction counters, and sequences RUN -> DRAIN -> DONE on halt.
// Optional feature macro: RETIRE_TRACE_PC_EN (per-record PC on trace_pc).
// Handshake: a record transfers on a cycle where trace_valid && trace_ready;
// trace_valid stays high and the head fields hold until that happens.
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_reg_write,
    input  logic [3:0]  wb_reg_sel,
    input  logic [15:0] wb_reg_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        hlt_in,
    input  logic [15:0] pc_in,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [3:0]  trace_flags,
    output logic [3:0]  trace_reg_sel,
    output logic [15:0] trace_reg_data,
    output logic [15:0] trace_mem_addr,
    output logic [15:0] trace_mem_data,
    output logic [15:0] trace_pc,
    output logic        stall_req,
    output logic        overflow,
    output logic        halted,
    output logic        done,
    output logic [31:0] cycle_count,
    output logic [31:0] inst_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] MARGIN_CNT = (AW+1)'(AFULL_MARGIN);

    trace_state_t state_q, state_d;
    logic         overflow_q, overflow_d;
    logic [31:0]  cycle_count_q, cycle_count_d;
    logic [31:0]  inst_count_q, inst_count_d;

    trace_rec_t   cap_rec;
    trace_rec_t   head_rec;
    logic         capture;
    logic         pop;
    logic         push_ok;
    logic         fifo_full;
    logic         fifo_empty;
    logic [AW:0]  occupancy;
    logic [AW:0]  free_cnt;

`ifndef RETIRE_TRACE_PC_EN
    logic pc_unused;
    assign pc_unused = ^pc_in;
`endif

    // Capture qualification and record packing for this cycle
    always_comb begin
        capture = (state_q == RUN) && (wb_reg_write || mem_read || mem_write || hlt_in);
        pop     = trace_valid && trace_ready;
        cap_rec = '0;
        cap_rec.flags[FLG_REG] = wb_reg_write;
        cap_rec.flags[FLG_LD]  = mem_read;
        cap_rec.flags[FLG_ST]  = mem_write;
        cap_rec.flags[FLG_HLT] = hlt_in;
        cap_rec.reg_sel  = wb_reg_sel;
        cap_rec.reg_data = wb_reg_data;
        cap_rec.mem_addr = mem_addr;
        cap_rec.mem_data = mem_write ? mem_wdata : mem_rdata;
`ifdef RETIRE_TRACE_PC_EN
        cap_rec.pc       = pc_in;
`endif
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .pop       (pop),
        .wr_rec    (cap_rec),
        .rd_rec    (head_rec),
        .push_ok   (push_ok),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    // Next-state for the halt/drain sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (hlt_in) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    // Sticky overflow and saturating counters
    always_comb begin
        overflow_d    = overflow_q;
        cycle_count_d = cycle_count_q;
        inst_count_d  = inst_count_q;
        if (capture && !push_ok) overflow_d = 1'b1;
        if ((state_q == RUN) && (cycle_count_q != 32'hFFFF_FFFF))
            cycle_count_d = cycle_count_q + 32'd1;
        if (capture && (wb_reg_write || mem_write || hlt_in) &&
            (inst_count_q != 32'hFFFF_FFFF))
            inst_count_d = inst_count_q + 32'd1;
    end

    // State, flag and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            overflow_q    <= 1'b0;
            cycle_count_q <= '0;
            inst_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            overflow_q    <= overflow_d;
            cycle_count_q <= cycle_count_d;
            inst_count_q  <= inst_count_d;
        end
    end

    // Outputs are driven only from registered state
    always_comb begin
        free_cnt       = DEPTH_CNT - occupancy;
        trace_valid    = !fifo_empty;
        trace_flags    = head_rec.flags;
        trace_reg_sel  = head_rec.reg_sel;
        trace_reg_data = head_rec.reg_data;
        trace_mem_addr = head_rec.mem_addr;
        trace_mem_data = head_rec.mem_data;
`ifdef RETIRE_TRACE_PC_EN
        trace_pc       = head_rec.pc;
`else
        trace_pc       = 16'h0000;
`endif
        stall_req      = (free_cnt <= MARGIN_CNT);
        overflow       = overflow_q;
        halted         = (state_q != RUN);
        done           = (state_q == DONE);
        cycle_count    = cycle_count_q;
        inst_count     = inst_count_q;
    end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer (default DEPTH=16, AFULL_MARGIN=2).
// Optional feature macro: RETIRE_TRACE_PC_EN (changes expected trace_pc).
module tb_retire_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_reg_write;
    logic [3:0]  wb_reg_sel;
    logic [15:0] wb_reg_data;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        hlt_in;
    logic [15:0] pc_in;
    logic        trace_valid;
    logic        trace_ready;
    logic [3:0]  trace_flags;
    logic [3:0]  trace_reg_sel;
    logic [15:0] trace_reg_data;
    logic [15:0] trace_mem_addr;
    logic [15:0] trace_mem_data;
    logic [15:0] trace_pc;
    logic        stall_req;
    logic        overflow;
    logic        halted;
    logic        done;
    logic [31:0] cycle_count;
    logic [31:0] inst_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    retire_trace_buffer #(.DEPTH(16), .AFULL_MARGIN(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_reg_write(wb_reg_write), .wb_reg_sel(wb_reg_sel), .wb_reg_data(wb_reg_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .hlt_in(hlt_in), .pc_in(pc_in),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_flags(trace_flags), .trace_reg_sel(trace_reg_sel),
        .trace_reg_data(trace_reg_data), .trace_mem_addr(trace_mem_addr),
        .trace_mem_data(trace_mem_data), .trace_pc(trace_pc),
        .stall_req(stall_req), .overflow(overflow), .halted(halted), .done(done),
        .cycle_count(cycle_count), .inst_count(inst_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; sampling and driving both happen 1 time unit after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_reg_write = 1'b0; wb_reg_sel = '0; wb_reg_data = '0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0;
        mem_wdata = '0; mem_rdata = '0; hlt_in = 1'b0; pc_in = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        trace_ready = 1'b0;
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic drive_wb(input logic [3:0] sel, input logic [15:0] data);
        idle_inputs();
        wb_reg_write = 1'b1; wb_reg_sel = sel; wb_reg_data = data;
        pc_in = data ^ 16'h5000;
        cyc();
        idle_inputs();
    endtask

    function automatic logic [15:0] exp_pc(input logic [15:0] p);
`ifdef RETIRE_TRACE_PC_EN
        return p;
`else
        return 16'h0000 & p;
`endif
    endfunction

    initial begin
        idle_inputs();
        trace_ready = 1'b0;
        do_reset();

        // Reset state
        check("rst_valid", {31'd0, trace_valid}, 0);
        check("rst_stall", {31'd0, stall_req}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        check("rst_halted", {31'd0, halted}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_cycles", cycle_count, 0);
        check("rst_insts", inst_count, 0);
        check("rst_flags", {28'd0, trace_flags}, 0);
        cyc();
        check("cycles_after_1", cycle_count, 1);

        // Single write-back
        drive_wb(4'd3, 16'h00A5);
        check("wb_valid", {31'd0, trace_valid}, 1);
        check("wb_flags", {28'd0, trace_flags}, 32'b0001);
        check("wb_sel", {28'd0, trace_reg_sel}, 3);
        check("wb_data", {16'd0, trace_reg_data}, 16'h00A5);
        check("wb_pc", {16'd0, trace_pc}, {16'd0, exp_pc(16'h50A5)});
        check("wb_insts", inst_count, 1);
        cyc();
        check("wb_hold_valid", {31'd0, trace_valid}, 1);
        check("wb_hold_data", {16'd0, trace_reg_data}, 16'h00A5);
        trace_ready = 1'b1;
        cyc();
        trace_ready = 1'b0;
        check("wb_popped", {31'd0, trace_valid}, 0);

        // Store then load with write-back
        mem_write = 1'b1; mem_addr = 16'h0010; mem_wdata = 16'h1234; mem_rdata = 16'hDEAD;
        cyc();
        idle_inputs();
        mem_read = 1'b1; mem_addr = 16'h0010; mem_rdata = 16'h1234; mem_wdata = 16'hBBBB;
        wb_reg_write = 1'b1; wb_reg_sel = 4'd5; wb_reg_data = 16'h1234;
        cyc();
        idle_inputs();
        check("st_flags", {28'd0, trace_flags}, 32'b0100);
        check("st_addr", {16'd0, trace_mem_addr}, 16'h0010);
        check("st_data", {16'd0, trace_mem_data}, 16'h1234);
        trace_ready = 1'b1;
        cyc();
        check("ld_flags", {28'd0, trace_flags}, 32'b0011);
        check("ld_data", {16'd0, trace_mem_data}, 16'h1234);
        check("ld_sel", {28'd0, trace_reg_sel}, 5);
        cyc();
        trace_ready = 1'b0;
        check("stld_empty", {31'd0, trace_valid}, 0);
        check("stld_insts", inst_count, 3);

        // Backpressure and overflow
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive_wb(i[3:0], 16'h0A00 + 16'(i));
            if (i < 16) exp_q.push_back(16'h0A00 + 16'(i));
            if (i == 12) check("bp_stall_13", {31'd0, stall_req}, 0);
            if (i == 13) check("bp_stall_14", {31'd0, stall_req}, 1);
            if (i == 15) check("bp_ovf_16", {31'd0, overflow}, 0);
        end
        check("bp_ovf_17", {31'd0, overflow}, 1);
        check("bp_insts", inst_count, 17);
        trace_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("bp_valid", {31'd0, trace_valid}, 1);
            check("bp_order", {16'd0, trace_reg_data}, {16'd0, exp_q.pop_front()});
            cyc();
        end
        trace_ready = 1'b0;
        check("bp_drained", {31'd0, trace_valid}, 0);
        check("bp_ovf_sticky", {31'd0, overflow}, 1);

        // Full with simultaneous pop and push
        do_reset();
        for (int i = 0; i < 16; i++) drive_wb(i[3:0], 16'h0B00 + 16'(i));
        check("fp_stall", {31'd0, stall_req}, 1);
        trace_ready = 1'b1;
        drive_wb(4'hF, 16'hBEEF);
        trace_ready = 1'b0;
        check("fp_no_ovf", {31'd0, overflow}, 0);
        check("fp_head", {16'd0, trace_reg_data}, 16'h0B01);
        check("fp_stall_kept", {31'd0, stall_req}, 1);
        trace_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("fp_order", {16'd0, trace_reg_data},
                  (k < 15) ? 32'h0B01 + 32'(k) : 32'hBEEF);
            cyc();
        end
        trace_ready = 1'b0;
        check("fp_drained", {31'd0, trace_valid}, 0);

        // Halt with three records queued
        do_reset();
        for (int i = 0; i < 3; i++) drive_wb(i[3:0], 16'h0100 + 16'(i));
        hlt_in = 1'b1; pc_in = 16'h0042;
        cyc();
        idle_inputs();
        check("h_halted", {31'd0, halted}, 1);
        check("h_done0", {31'd0, done}, 0);
        check("h_cycles", cycle_count, 4);
        check("h_insts", inst_count, 4);
        for (int i = 0; i < 3; i++) drive_wb(4'd9, 16'h7777);
        check("h_cycles_frozen", cycle_count, 4);
        check("h_insts_frozen", inst_count, 4);
        trace_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("h_order", {16'd0, trace_reg_data}, 32'h0100 + 32'(k));
            cyc();
        end
        check("h_last_flags", {28'd0, trace_flags}, 32'b1000);
        check("h_last_pc", {16'd0, trace_pc}, {16'd0, exp_pc(16'h0042)});
        check("h_done_before_last", {31'd0, done}, 0);
        cyc();
        trace_ready = 1'b0;
        check("h_empty", {31'd0, trace_valid}, 0);
        begin
            int waited = 0;
            while (!done && waited < 4) begin
                cyc();
                waited++;
            end
            check("h_done", {31'd0, done}, 1);
            check("h_done_latency", waited, 1);
        end

        // Reset mid-drain with five records queued
        do_reset();
        for (int i = 0; i < 4; i++) drive_wb(i[3:0], 16'h0C00 + 16'(i));
        hlt_in = 1'b1;
        cyc();
        idle_inputs();
        check("rd_halted", {31'd0, halted}, 1);
        check("rd_valid_pre", {31'd0, trace_valid}, 1);
        rst_n = 1'b0;
        cyc();
        check("rd_valid", {31'd0, trace_valid}, 0);
        check("rd_cycles", cycle_count, 0);
        check("rd_insts", inst_count, 0);
        check("rd_halted0", {31'd0, halted}, 0);
        check("rd_ovf", {31'd0, overflow}, 0);
        rst_n = 1'b1;
        cyc();
        check("rd_run_counts", cycle_count, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
